// File: rtl/pulse_drive_module.sv
// pulse_drive_module: turns one-cycle requests into queued pin pulses with min high time and min low gap; ports CLOCK/RST in, Trig_In request, Pin_Out drive, Busy, Pend_Cnt queued count, Drop_Sig overflow flag
module pulse_drive_module #(
  parameter int HIGH_CNT = 500000,
  parameter int GAP_CNT  = 500000,
  parameter int CNT_W    = 20,
  parameter int QUEUE_W  = 4
) (
  input  logic               CLOCK,
  input  logic               RST,
  input  logic               Trig_In,
  output logic               Pin_Out,
  output logic               Busy,
  output logic [QUEUE_W-1:0] Pend_Cnt,
  output logic               Drop_Sig
);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QUEUE_W-1:0] pend_q, pend_d;
  logic pin_q, pin_d, busy_q, busy_d, drop_q, drop_d;
  logic gap_end, take_q, fire;
  always_comb begin
    gap_end = state_q == GAP && cnt_q == '0;
    take_q  = gap_end && pend_q != '0;
    fire    = (state_q == IDLE && Trig_In) || (gap_end && (take_q || Trig_In));
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    if (fire) begin
      state_d = HIGH;
      cnt_d   = CNT_W'(HIGH_CNT - 1);
    end else if (state_q == HIGH && cnt_q == '0) begin
      state_d = GAP;
      cnt_d   = CNT_W'(GAP_CNT - 1);
    end else if (gap_end || state_q == IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    pend_d = pend_q;
    drop_d = 1'b0;
    // At the end of a gap an arriving request is either consumed directly or
    // swaps places with the queued one it displaces, so the count holds.
    if (state_q != IDLE) begin
      if (Trig_In && !gap_end) begin
        drop_d = &pend_q;
        pend_d = &pend_q ? pend_q : pend_q + QUEUE_W'(1);
      end else if (!Trig_In && take_q) begin
        pend_d = pend_q - QUEUE_W'(1);
      end
    end
    pin_d  = state_d == HIGH;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      pin_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end
  assign Pin_Out  = pin_q;
  assign Busy     = busy_q;
  assign Pend_Cnt = pend_q;
  assign Drop_Sig = drop_q;
endmodule

// File: doc/pulse_drive_module.md
Name: pulse_drive_module

Overview:
- Output-side counterpart to the pin debouncer.
- The debouncer turns a noisy pin into clean internal events. This block turns clean internal one-cycle requests into a pin waveform with a guaranteed minimum high time and minimum low gap.
- It queues requests that arrive while a pulse is running, so they are not lost.
- Sits between control logic (GPIO/PWM demo core) and an output pin: LED, buzzer, relay, or a remote debounced input.

Parameters:
- HIGH_CNT, 500000: Pin_Out high duration in CLOCK cycles (10 ms at 50 MHz). Must be ≥ 1.
- GAP_CNT, 500000: minimum Pin_Out low duration after each pulse, in CLOCK cycles. Must be ≥ 1.
- CNT_W, 20: width of the shared duration counter. Must hold max(HIGH_CNT, GAP_CNT) − 1.
- QUEUE_W, 4: width of the pending-request counter. Maximum pending = 2^QUEUE_W − 1.

Ports:
- CLOCK, input, 1: system clock. Everything is on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- Trig_In, input, 1: pulse request. Each cycle it is high counts as one request.
- Pin_Out, output, 1: registered pin drive.
- Busy, output, 1: registered; high whenever state ≠ IDLE.
- Pend_Cnt, output, QUEUE_W: registered count of queued, not-yet-started pulses.
- Drop_Sig, output, 1: registered one-cycle flag; a request was discarded on overflow.

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-high. The clock and reset ports are CLOCK and RST.
  - While RST is high at an edge: state = IDLE, Pin_Out = 0, Busy = 0, Pend_Cnt = 0, Drop_Sig = 0, counter = 0. This applies mid-pulse too: the pulse is truncated and the queue is flushed.
- Counter: one down-counter of CNT_W bits.
- IDLE
  - Trig_In high → go to HIGH, Pin_Out ← 1, counter ← HIGH_CNT − 1.
  - Latency is 1 cycle: Pin_Out is high starting the cycle after Trig_In is sampled.
  - A request consumed in its arrival cycle is never added to Pend_Cnt.
  - Pend_Cnt is always 0 in IDLE.
- HIGH
  - Pin_Out = 1 for exactly HIGH_CNT cycles.
  - When counter = 0 → go to GAP, Pin_Out ← 0, counter ← GAP_CNT − 1. Otherwise decrement.
- GAP
  - Pin_Out = 0 for exactly GAP_CNT cycles.
  - When counter = 0 and (Pend_Cnt > 0 or Trig_In) → go to HIGH, Pin_Out ← 1, counter ← HIGH_CNT − 1.
    - If Pend_Cnt > 0, one queued request is consumed.
    - Otherwise the current Trig_In is consumed directly.
  - When counter = 0 and no request → go to IDLE.
  - Back-to-back period is therefore exactly HIGH_CNT + GAP_CNT cycles.
- Queue accounting (HIGH/GAP only)
  - Trig_In high and no consume → Pend_Cnt + 1.
  - Consume and Trig_In high in the same cycle (GAP end, Pend_Cnt > 0) → Pend_Cnt unchanged.
  - Consume only → Pend_Cnt − 1.
- Overflow
  - Trig_In high, Pend_Cnt = max, and no consume that cycle → request discarded, Pend_Cnt holds at max, Drop_Sig = 1 the next cycle.
  - Drop_Sig otherwise 0.
  - Pend_Cnt never wraps; there is no underflow path.
- Busy = 1 in HIGH and GAP, registered with the state.
- Pin_Out is driven directly from a flop; it never glitches.

Test Plan:
Use HIGH_CNT = 4, GAP_CNT = 3, QUEUE_W = 2 (max pending 3). Cycle N means the edge where Trig_In is sampled.
1. Single request, Trig_In at cycle 10 → Pin_Out high cycles 11–14, low 15–17; Busy high 11–17, low from 18; Pend_Cnt stays 0.
2. Two requests, Trig_In at 10 and 12 → Pend_Cnt = 1 during 13–17; second pulse high 18–21, gap 22–24; Busy low at 25; Pend_Cnt = 0 from 18.
3. Overflow, Trig_In held high cycles 10–14 → first consumed, Pend_Cnt reaches 3 at 14; Drop_Sig = 1 at cycle 15 only; exactly four pulses total, starting at 11, 18, 25, 32.
4. Simultaneous consume and arrive:
   - Pend_Cnt = 1 and Trig_In on the last GAP cycle → new pulse starts next cycle, Pend_Cnt remains 1.
   - Same with Pend_Cnt = 0 → new pulse starts, Pend_Cnt stays 0, no idle cycle.
5. Reset mid-operation, Trig_In at 10 and 11, RST high at cycle 12 → from 13: Pin_Out = 0, Busy = 0, Pend_Cnt = 0; no further pulses without new Trig_In.
6. Minimum parameters, HIGH_CNT = 1, GAP_CNT = 1, Trig_In held high for 6 cycles → Pin_Out alternates 1/0 each cycle; no pulse shorter than 1 high + 1 low.
